// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dm_access_ctrl
// Description : Two-port data-memory access controller (pipeline MEM port 0,
//               secondary master port 1) sharing one synchronous memory.
//               Round-robin arbitration when DM_ACCESS_RR_EN is defined,
//               fixed priority (port 0) otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_access_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic        m0_sext,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic        m1_sext,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] c_lat_m1 = 2'(MEM_LAT - 1);

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_port;
    logic        r_we;
    logic        r_sext;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_err;
`ifdef DM_ACCESS_RR_EN
    logic        r_last;
`endif

    logic        w_any;
    logic        w_sel;
    logic        w_we;
    logic        w_sext;
    logic [1:0]  w_size;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [31:0] w_wlane;
    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    always_comb begin
        w_any = m0_req | m1_req;
`ifdef DM_ACCESS_RR_EN
        // r_last = 1 means port 1 was granted last, so port 0 wins a tie
        w_sel = m1_req & (~m0_req | ~r_last);
`else
        w_sel = ~m0_req;
`endif
        w_we    = w_sel ? m1_we    : m0_we;
        w_sext  = w_sel ? m1_sext  : m0_sext;
        w_size  = w_sel ? m1_size  : m0_size;
        w_addr  = w_sel ? m1_addr  : m0_addr;
        w_wdata = w_sel ? m1_wdata : m0_wdata;
        w_be    = 4'b0000;
        w_wlane = 32'h0;
        w_err   = 1'b0;
        case (w_size)
            2'b00: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_wlane = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{w_wdata[15:0]}};
                w_err   = w_addr[0];
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wlane = w_wdata;
                w_err   = |w_addr[1:0];
            end
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        case (r_off)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_size)
            2'b00:   w_ext = {{24{r_sext & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{r_sext & w_half[15]}}, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= 2'd0;
            r_port    <= 1'b0;
            r_we      <= 1'b0;
            r_sext    <= 1'b0;
            r_size    <= 2'b00;
            r_off     <= 2'b00;
            r_err     <= 1'b0;
`ifdef DM_ACCESS_RR_EN
            r_last    <= 1'b1;
`endif
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_done   <= 1'b0;
            m1_done   <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            m0_rdata  <= 32'h0;
            m1_rdata  <= 32'h0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= ACCESS;
                        r_port  <= w_sel;
                        r_we    <= w_we;
                        r_sext  <= w_sext;
                        r_size  <= w_size;
                        r_off   <= w_addr[1:0];
                        r_err   <= w_err;
`ifdef DM_ACCESS_RR_EN
                        r_last  <= w_sel;
`endif
                        m0_gnt  <= ~w_sel;
                        m1_gnt  <= w_sel;
                        if (!w_err) begin
                            mem_en    <= 1'b1;
                            mem_we    <= w_we;
                            mem_addr  <= {w_addr[31:2], 2'b00};
                            mem_be    <= w_be;
                            mem_wdata <= w_we ? w_wlane : 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    m0_gnt    <= 1'b0;
                    m1_gnt    <= 1'b0;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= 32'h0;
                    mem_be    <= 4'b0000;
                    mem_wdata <= 32'h0;
                    if (!r_err && !r_we) begin
                        r_state <= WAIT;
                        r_cnt   <= c_lat_m1;
                    end else begin
                        r_state <= DONE;
                        m0_done <= ~r_port;
                        m1_done <= r_port;
                        m0_err  <= ~r_port & r_err;
                        m1_err  <= r_port & r_err;
                    end
                end
                WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_state <= DONE;
                        m0_done <= ~r_port;
                        m1_done <= r_port;
                        if (r_port) m1_rdata <= w_ext;
                        else        m0_rdata <= w_ext;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    m0_done  <= 1'b0;
                    m1_done  <= 1'b0;
                    m0_err   <= 1'b0;
                    m1_err   <= 1'b0;
                    m0_rdata <= 32'h0;
                    m1_rdata <= 32'h0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_access_ctrl
// Description : Directed bench for dm_access_ctrl; instance a uses MEM_LAT=1,
//               instance b uses MEM_LAT=3, both driven by the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_access_ctrl;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m0_sext;
    logic [1:0]  m0_size;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we, m1_sext;
    logic [1:0]  m1_size;
    logic [31:0] m1_addr, m1_wdata;
    logic [31:0] mem_rdata;

    logic        a_m0_gnt, a_m0_done, a_m0_err, a_m1_gnt, a_m1_done, a_m1_err;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata;
    logic        a_mem_en, a_mem_we;
    logic [3:0]  a_mem_be;
    logic        b_m0_gnt, b_m0_done, b_m0_err, b_m1_gnt, b_m1_done, b_m1_err;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
    logic        b_mem_en, b_mem_we;
    logic [3:0]  b_mem_be;

    int n_checks = 0;
    int n_errors = 0;

    dm_access_ctrl #(.MEM_LAT(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_sext(m0_sext),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_done(a_m0_done), .m0_err(a_m0_err), .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_sext(m1_sext),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_done(a_m1_done), .m1_err(a_m1_err), .m1_rdata(a_m1_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_be(a_mem_be),
        .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata)
    );

    dm_access_ctrl #(.MEM_LAT(3)) u_dut_b (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_sext(m0_sext),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_done(b_m0_done), .m0_err(b_m0_err), .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_sext(m1_sext),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_done(b_m1_done), .m1_err(b_m1_err), .m1_rdata(b_m1_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
        .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (4) step();
    endtask

    task automatic set_m0(input logic we, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata);
        m0_we = we; m0_size = size; m0_sext = sext; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic set_m1(input logic we, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata);
        m1_we = we; m1_size = size; m1_sext = sext; m1_addr = addr; m1_wdata = wdata;
    endtask

    initial begin
        logic exp1;
        reset = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        set_m0(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_en", {31'h0, a_mem_en}, 32'h0);
        check("rst_m0_done", {31'h0, a_m0_done}, 32'h0);
        check("rst_m1_gnt", {31'h0, a_m1_gnt}, 32'h0);
        reset = 1'b1;
        step();

        // signed byte load, lane 3
        set_m0(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        mem_rdata = 32'h80AA5566;
        m0_req = 1'b1;
        step();
        check("sb_gnt", {31'h0, a_m0_gnt}, 32'h1);
        check("sb_mem_en", {31'h0, a_mem_en}, 32'h1);
        check("sb_mem_we", {31'h0, a_mem_we}, 32'h0);
        check("sb_addr", a_mem_addr, 32'h10);
        check("sb_be", {28'h0, a_mem_be}, 32'h8);
        step();
        check("sb_gnt_off", {31'h0, a_m0_gnt}, 32'h0);
        check("sb_early_done", {31'h0, a_m0_done}, 32'h0);
        check("sb_mem_off", {31'h0, a_mem_en}, 32'h0);
        step();
        check("sb_done", {31'h0, a_m0_done}, 32'h1);
        check("sb_rdata", a_m0_rdata, 32'hFFFFFF80);
        check("sb_err", {31'h0, a_m0_err}, 32'h0);
        m0_req = 1'b0;
        step();
        check("sb_done_off", {31'h0, a_m0_done}, 32'h0);
        check("sb_rdata_off", a_m0_rdata, 32'h0);
        repeat (3) step();

        // unsigned half load, upper half; also checks the MEM_LAT=3 instance
        set_m0(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
        mem_rdata = 32'h80011234;
        m0_req = 1'b1;
        step();
        check("uh_be", {28'h0, a_mem_be}, 32'hC);
        check("uh_addr", a_mem_addr, 32'h0);
        step(); step();
        check("uh_rdata", a_m0_rdata, 32'h00008001);
        check("uh_lat3_early", {31'h0, b_m0_done}, 32'h0);
        m0_req = 1'b0;
        step();
        check("uh_lat3_early2", {31'h0, b_m0_done}, 32'h0);
        step();
        check("uh_lat3_done", {31'h0, b_m0_done}, 32'h1);
        check("uh_lat3_rdata", b_m0_rdata, 32'h00008001);
        gap();

        // half store on port 1
        set_m1(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF);
        m1_req = 1'b1;
        step();
        check("hs_gnt1", {31'h0, a_m1_gnt}, 32'h1);
        check("hs_gnt0", {31'h0, a_m0_gnt}, 32'h0);
        check("hs_we", {31'h0, a_mem_we}, 32'h1);
        check("hs_addr", a_mem_addr, 32'h20);
        check("hs_be", {28'h0, a_mem_be}, 32'hC);
        check("hs_wdata", a_mem_wdata, 32'hBEEFBEEF);
        step();
        check("hs_done", {31'h0, a_m1_done}, 32'h1);
        check("hs_err", {31'h0, a_m1_err}, 32'h0);
        check("hs_m0_done", {31'h0, a_m0_done}, 32'h0);
        gap();

        // misaligned word load
        set_m0(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        mem_rdata = 32'hFFFFFFFF;
        m0_req = 1'b1;
        step();
        check("mw_gnt", {31'h0, a_m0_gnt}, 32'h1);
        check("mw_mem_en", {31'h0, a_mem_en}, 32'h0);
        check("mw_be", {28'h0, a_mem_be}, 32'h0);
        step();
        check("mw_done", {31'h0, a_m0_done}, 32'h1);
        check("mw_err", {31'h0, a_m0_err}, 32'h1);
        check("mw_rdata", a_m0_rdata, 32'h0);
        gap();

        // byte store at offset 1
        set_m0(1'b1, 2'b00, 1'b0, 32'h101, 32'h12345678);
        m0_req = 1'b1;
        step();
        check("bs_be", {28'h0, a_mem_be}, 32'h2);
        check("bs_addr", a_mem_addr, 32'h100);
        check("bs_wdata", a_mem_wdata, 32'h78787878);
        step();
        check("bs_done", {31'h0, a_m0_done}, 32'h1);
        gap();

        // illegal size on port 1
        set_m1(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
        m1_req = 1'b1;
        step();
        check("il_mem_en", {31'h0, a_mem_en}, 32'h0);
        step();
        check("il_err", {31'h0, a_m1_err}, 32'h1);
        gap();

        // signed half load, lower half, port 1
        set_m1(1'b0, 2'b01, 1'b1, 32'h40, 32'h0);
        mem_rdata = 32'h7777F00D;
        m1_req = 1'b1;
        step(); step(); step();
        check("sh_done", {31'h0, a_m1_done}, 32'h1);
        check("sh_rdata", a_m1_rdata, 32'hFFFFF00D);
        gap();

        // contention: fresh reset so the first tie goes to port 0
        reset = 1'b0;
        #3 reset = 1'b1;
        step();
        set_m0(1'b1, 2'b00, 1'b0, 32'h0, 32'h11);
        set_m1(1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFEF00D);
        m0_req = 1'b1;
        m1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef DM_ACCESS_RR_EN
            exp1 = i[0];
`else
            exp1 = 1'b0;
`endif
            check($sformatf("ct_gnt0_%0d", i), {31'h0, a_m0_gnt}, {31'h0, ~exp1});
            check($sformatf("ct_gnt1_%0d", i), {31'h0, a_m1_gnt}, {31'h0, exp1});
            check($sformatf("ct_be_%0d", i), {28'h0, a_mem_be}, exp1 ? 32'hF : 32'h1);
            step(); step();
        end
        gap();

        // asynchronous reset while in ACCESS
        set_m1(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        mem_rdata = 32'hDEADBEEF;
        m1_req = 1'b1;
        step();
        check("ra_gnt_pre", {31'h0, a_m1_gnt}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("ra_gnt", {31'h0, a_m1_gnt}, 32'h0);
        check("ra_mem_en", {31'h0, a_mem_en}, 32'h0);
        check("ra_addr_b", b_mem_addr, 32'h0);
        m1_req = 1'b0;
        #1 reset = 1'b1;
        gap();

        // reset while instance b is in WAIT and instance a shows done
        m1_req = 1'b1;
        step(); step(); step();
        check("rw_a_done_pre", {31'h0, a_m1_done}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("rw_a_done", {31'h0, a_m1_done}, 32'h0);
        check("rw_a_rdata", a_m1_rdata, 32'h0);
        m1_req = 1'b0;
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rw_b_nodone_%0d", i), {31'h0, b_m1_done}, 32'h0);
        end

        // normal load after release on the MEM_LAT=3 instance
        set_m1(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        mem_rdata = 32'h12345678;
        m1_req = 1'b1;
        step();
        check("rl_b_gnt", {31'h0, b_m1_gnt}, 32'h1);
        step(); step(); step();
        check("rl_b_early", {31'h0, b_m1_done}, 32'h0);
        step();
        check("rl_b_done", {31'h0, b_m1_done}, 32'h1);
        check("rl_b_rdata", b_m1_rdata, 32'h12345678);
        m1_req = 1'b0;
        step();
        check("rl_b_rdata_off", b_m1_rdata, 32'h0);
        gap();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
